// File: rtl/data_mem_ctrl.sv
// Handshaked byte-addressable data memory with sized, extended loads and range faults.
// Build option: define DMEM_MISALIGN_SPLIT_EN to split misaligned accesses over two words.
module data_mem_ctrl #(
  parameter int unsigned MEM_SIZE   = 1024,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned SIZE_W     = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_we,
  input  logic [DATA_WIDTH-1:0] i_req_addr,
  input  logic [SIZE_W-1:0]     i_req_size,
  input  logic                  i_req_unsigned,
  input  logic [DATA_WIDTH-1:0] i_req_wdata,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [DATA_WIDTH-1:0] o_rsp_rdata,
  output logic                  o_rsp_err
);

  localparam int unsigned B     = DATA_WIDTH / 8;
  localparam int unsigned LB    = $clog2(B);
  localparam int unsigned WORDS = MEM_SIZE / B;
  localparam int unsigned WAW   = $clog2(WORDS);
  localparam int unsigned AW    = DATA_WIDTH + 1;
`ifdef DMEM_MISALIGN_SPLIT_EN
  localparam int unsigned SPAN  = 2 * B;
`else
  localparam int unsigned SPAN  = B;
`endif

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ACC0 = 2'd1;
  localparam logic [1:0] ACC1 = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  logic [DATA_WIDTH-1:0] mem [WORDS] = '{default: '0};

  logic [1:0]            state;
  logic [LB+WAW-1:0]     addr_q;
  logic [SIZE_W-1:0]     size_q;
  logic                  we_q;
  logic                  uns_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  logic [AW-1:0]         req_nb;
  logic [AW-1:0]         req_end;
  logic                  req_fault;

  // Request checks; the range test uses the last byte so a straddling access at the top faults.
  always_comb begin
    req_nb    = AW'(1) << i_req_size;
    req_end   = {1'b0, i_req_addr} + req_nb;
    req_fault = (int'(i_req_size) > int'(LB)) || (req_end > AW'(MEM_SIZE));
`ifdef DMEM_MISALIGN_SPLIT_EN
`else
    req_fault = req_fault || ((i_req_addr & (req_nb[DATA_WIDTH-1:0] - 1'b1)) != '0);
`endif
  end

  logic [LB-1:0]         off;
  logic [WAW-1:0]        word0;
  int                    nb;
  logic [SPAN-1:0]       be;
  logic [8*SPAN-1:0]     wd;
  logic [LB-1:0]         lane;
  logic [DATA_WIDTH-1:0] ld_cur;
  logic [DATA_WIDTH-1:0] ld_ext;
  int                    nbits;

  assign off   = addr_q[LB-1:0];
  assign word0 = addr_q[LB +: WAW];
  assign nb    = 1 << size_q;

  // Span byte i carries store byte (i - off); lane wraps modulo the word size.
  always_comb begin
    be   = '0;
    wd   = '0;
    lane = '0;
    for (int i = 0; i < int'(SPAN); i++) begin
      lane           = LB'(i) - off;
      be[i]          = (i >= int'(off)) && (i < int'(off) + nb);
      wd[8*i +: 8]   = wdata_q[8*lane +: 8];
    end
  end

`ifdef DMEM_MISALIGN_SPLIT_EN
  logic [WAW-1:0]        word1;
  logic [DATA_WIDTH-1:0] ld_q;
  logic                  split;
  assign word1 = word0 + 1'b1;
  assign split = (int'(off) + nb) > int'(B);
`endif

  always_comb begin
    ld_cur = mem[word0] >> (8 * off);
`ifdef DMEM_MISALIGN_SPLIT_EN
    if (state == ACC1) begin
      ld_cur = ld_q | (mem[word1] << (8 * (int'(B) - int'(off))));
    end
`endif
    nbits  = (int'(size_q) > int'(LB)) ? DATA_WIDTH : (8 << size_q);
    ld_ext = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (i < nbits) ld_ext[i] = ld_cur[i];
      else           ld_ext[i] = uns_q ? 1'b0 : ld_cur[nbits-1];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= IDLE;
      addr_q      <= '0;
      size_q      <= '0;
      we_q        <= 1'b0;
      uns_q       <= 1'b0;
      wdata_q     <= '0;
      o_rsp_rdata <= '0;
      o_rsp_err   <= 1'b0;
`ifdef DMEM_MISALIGN_SPLIT_EN
      ld_q        <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (i_req_valid) begin
            addr_q  <= i_req_addr[LB+WAW-1:0];
            size_q  <= i_req_size;
            we_q    <= i_req_we;
            uns_q   <= i_req_unsigned;
            wdata_q <= i_req_wdata;
            o_rsp_rdata <= '0;
            o_rsp_err   <= req_fault;
            state       <= req_fault ? RESP : ACC0;
          end
        end
        ACC0: begin
`ifdef DMEM_MISALIGN_SPLIT_EN
          ld_q <= ld_cur;
          if (split) begin
            state <= ACC1;
          end else begin
            o_rsp_rdata <= we_q ? '0 : ld_ext;
            state       <= RESP;
          end
`else
          o_rsp_rdata <= we_q ? '0 : ld_ext;
          state       <= RESP;
`endif
        end
`ifdef DMEM_MISALIGN_SPLIT_EN
        ACC1: begin
          o_rsp_rdata <= we_q ? '0 : ld_ext;
          state       <= RESP;
        end
`endif
        RESP: begin
          if (i_rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Memory contents survive reset; an abort after ACC0 leaves that half committed.
  always_ff @(posedge i_clk) begin
    if (state == ACC0 && we_q) begin
      for (int i = 0; i < int'(B); i++) begin
        if (be[i]) mem[word0][8*i +: 8] <= wd[8*i +: 8];
      end
    end
`ifdef DMEM_MISALIGN_SPLIT_EN
    if (state == ACC1 && we_q) begin
      for (int i = 0; i < int'(B); i++) begin
        if (be[B+i]) mem[word1][8*i +: 8] <= wd[8*(B+i) +: 8];
      end
    end
`endif
  end

  assign o_req_ready = (state == IDLE);
  assign o_rsp_valid = (state == RESP);

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: byte-array reference model checked every cycle plus literal vectors.
module tb_data_mem_ctrl;
  localparam int MS = 1024;
`ifdef DMEM_MISALIGN_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [1:0]  req_size = '0;
  logic        req_uns = 1'b0;
  logic [31:0] req_wdata = '0;
  logic        rsp_ready = 1'b0;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  always #5 clk = ~clk;

  data_mem_ctrl #(.MEM_SIZE(MS), .DATA_WIDTH(32), .SIZE_W(2)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_req_valid    (req_valid),
    .o_req_ready    (req_ready),
    .i_req_we       (req_we),
    .i_req_addr     (req_addr),
    .i_req_size     (req_size),
    .i_req_unsigned (req_uns),
    .i_req_wdata    (req_wdata),
    .o_rsp_valid    (rsp_valid),
    .i_rsp_ready    (rsp_ready),
    .o_rsp_rdata    (rsp_rdata),
    .o_rsp_err      (rsp_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h, expected %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a flat byte array plus the one outstanding transaction.
  bit [7:0]    mm [MS];
  bit          busy = 1'b0;
  int          age = 0;
  int          lat = 1;
  longint      m_addr = 0;
  int          m_nb = 1;
  bit          m_we = 1'b0;
  bit          m_err = 1'b0;
  logic [31:0] m_wdata = '0;
  logic [31:0] m_rdata = '0;

  always @(posedge rst) busy = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      busy = 1'b0;
    end else if (!busy) begin
      if (req_valid) begin
        m_addr  = longint'(req_addr);
        m_nb    = 1 << req_size;
        m_we    = req_we;
        m_wdata = req_wdata;
        m_err   = (req_size > 2) || (m_addr + m_nb > MS) || (!SPLIT && (m_addr % m_nb) != 0);
        lat     = m_err ? 1 : (((m_addr % 4) + m_nb > 4) ? 3 : 2);
        m_rdata = '0;
        if (!m_err && !m_we) begin
          for (int i = 0; i < m_nb; i++) m_rdata |= 32'(mm[m_addr + i]) << (8 * i);
          if (m_nb < 4 && !req_uns && m_rdata[8*m_nb-1])
            m_rdata |= ~((32'd1 << (8 * m_nb)) - 32'd1);
        end
        busy = 1'b1;
        age  = 0;
      end
    end else if (age >= lat - 1 && rsp_ready) begin
      busy = 1'b0;
    end else begin
      age++;
      if (m_we && !m_err) begin
        for (int i = 0; i < m_nb; i++) begin
          bit same;
          same = ((m_addr + i) / 4) == (m_addr / 4);
          if ((age == 1 && same) || (age == 2 && !same)) mm[m_addr + i] = m_wdata[8*i +: 8];
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      check("rst_req_ready", 32'(req_ready), 32'd1);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rdata", rsp_rdata, 32'd0);
      check("rst_err", 32'(rsp_err), 32'd0);
    end else begin
      bit ev;
      ev = busy && (age >= lat - 1);
      check("req_ready", 32'(req_ready), 32'(!busy));
      check("rsp_valid", 32'(rsp_valid), 32'(ev));
      if (ev) begin
        check("model_rdata", rsp_rdata, m_rdata);
        check("model_err", 32'(rsp_err), 32'(m_err));
      end
    end
  end

  // One request with literal expectations; stall>0 holds the response and pokes a request.
  task automatic do_req(input string nm, input bit we, input logic [31:0] addr,
                        input logic [1:0] size, input bit uns, input logic [31:0] wd,
                        input int stall, input logic [31:0] lit_rd, input bit lit_err,
                        input int lit_lat);
    int  k;
    bit  seen;
    @(posedge clk); #2;
    req_we = we; req_addr = addr; req_size = size; req_uns = uns; req_wdata = wd;
    req_valid = 1'b1;
    @(posedge clk); #2;
    req_valid = 1'b0;
    seen = 1'b0;
    k = 0;
    while (!seen && k < 10) begin
      k++;
      @(negedge clk);
      seen = rsp_valid;
    end
    if (!seen) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: got no response, expected one within 10 cycles", nm);
      return;
    end
    check({nm, "_lat"}, 32'(k), 32'(lit_lat));
    check({nm, "_rdata"}, rsp_rdata, lit_rd);
    check({nm, "_err"}, 32'(rsp_err), 32'(lit_err));
    repeat (stall) begin
      @(posedge clk); #2;
      req_we = 1'b1; req_addr = 32'h10; req_size = 2'd2; req_wdata = 32'h12345678;
      req_valid = 1'b1;
    end
    @(posedge clk); #2;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #2;
    rsp_ready = 1'b0;
    check({nm, "_idle"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    do_req("st_w10",   1, 32'h10, 2, 0, 32'hDEADBEEF, 0, 32'h0, 0, 2);
    do_req("ld_b13s",  0, 32'h13, 0, 0, 32'h0, 0, 32'hFFFFFFDE, 0, 2);
    do_req("ld_b13u",  0, 32'h13, 0, 1, 32'h0, 0, 32'h000000DE, 0, 2);
    do_req("ld_w10",   0, 32'h10, 2, 0, 32'h0, 0, 32'hDEADBEEF, 0, 2);
    do_req("st_h22",   1, 32'h22, 1, 0, 32'hFFFF8001, 0, 32'h0, 0, 2);
    do_req("ld_h22s",  0, 32'h22, 1, 0, 32'h0, 0, 32'hFFFF8001, 0, 2);
    do_req("ld_w20",   0, 32'h20, 2, 0, 32'h0, 0, 32'h80010000, 0, 2);

    if (SPLIT) begin
      do_req("st_w41", 1, 32'h41, 2, 0, 32'hA1B2C3D4, 0, 32'h0, 0, 3);
      do_req("ld_w40", 0, 32'h40, 2, 0, 32'h0, 0, 32'hB2C3D400, 0, 2);
      do_req("ld_w44", 0, 32'h44, 2, 0, 32'h0, 0, 32'h000000A1, 0, 2);
      do_req("ld_w41", 0, 32'h41, 2, 0, 32'h0, 0, 32'hA1B2C3D4, 0, 3);
    end else begin
      do_req("st_w41", 1, 32'h41, 2, 0, 32'hA1B2C3D4, 0, 32'h0, 1, 1);
      do_req("ld_w40", 0, 32'h40, 2, 0, 32'h0, 0, 32'h00000000, 0, 2);
      do_req("ld_w44", 0, 32'h44, 2, 0, 32'h0, 0, 32'h00000000, 0, 2);
      do_req("ld_w41", 0, 32'h41, 2, 0, 32'h0, 0, 32'h0, 1, 1);
    end

    do_req("ld_w3fe",  0, 32'h3FE, 2, 0, 32'h0, 0, 32'h0, 1, 1);
    do_req("ld_w400",  0, 32'h400, 2, 0, 32'h0, 0, 32'h0, 1, 1);
    do_req("ld_b3ff",  0, 32'h3FF, 0, 0, 32'h0, 0, 32'h0, 0, 2);
    do_req("st_b3ff",  1, 32'h3FF, 0, 0, 32'h123456A5, 0, 32'h0, 0, 2);
    do_req("ld_b3ffs", 0, 32'h3FF, 0, 0, 32'h0, 0, 32'hFFFFFFA5, 0, 2);
    do_req("ld_b3ffu", 0, 32'h3FF, 0, 1, 32'h0, 0, 32'h000000A5, 0, 2);
    do_req("sz3",      0, 32'h0, 3, 0, 32'h0, 0, 32'h0, 1, 1);

    do_req("bp_ld10",  0, 32'h10, 2, 0, 32'h0, 5, 32'hDEADBEEF, 0, 2);
    do_req("bp_re10",  0, 32'h10, 2, 0, 32'h0, 0, 32'hDEADBEEF, 0, 2);

    // Abort a split store while its second word is pending.
    @(posedge clk); #2;
    req_we = 1'b1; req_addr = 32'h81; req_size = 2'd2; req_wdata = 32'hFFFFFFFF;
    req_valid = 1'b1;
    @(posedge clk); #2;
    req_valid = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("abort_valid", 32'(rsp_valid), 32'd0);
    check("abort_ready", 32'(req_ready), 32'd1);
    check("abort_rdata", rsp_rdata, 32'd0);
    check("abort_err", 32'(rsp_err), 32'd0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    do_req("ab_ld80", 0, 32'h80, 2, 0, 32'h0, 0, SPLIT ? 32'hFFFFFF00 : 32'h0, 0, 2);
    do_req("ab_ld84", 0, 32'h84, 2, 0, 32'h0, 0, 32'h00000000, 0, 2);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
